mul_div_unit: RTL and testbench
===============================

Name: mul_div_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the decode control unit.
- Consumes the 5-bit ALUOP the decoder produces for R-type instructions: ALUOP = {FUNCT3[2:0], FUNCT7[5], FUNCT7[0]}. ALUOP[0]=1 marks an M-extension operation.
- Drives BUSY to the hazard/stall logic while computing. Returns the result with its destination register tag to the EX/MEM path.

Parameters:
- WIDTH, 32, operand/result width. Only 32 is supported because the ALUOP encoding is RV32.
- ITERATIONS, 32, shift-add / restoring-divide steps. Must equal WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- RESET  input  1  asynchronous, active-low reset.
- START  input  1  request; sampled at a rising edge.
- FLUSH  input  1  synchronous abort from branch/jump resolution.
- ALUOP  input  5  {FUNCT3, FUNCT7[5], FUNCT7[0]} from the control unit.
- DATA1  input  32  rs1 operand (multiplicand/dividend).
- DATA2  input  32  rs2 operand (multiplier/divisor).
- RD_IN  input  5  destination register index.
- BUSY  output  1  high while an operation is in flight; pipeline stalls on it.
- VALID  output  1  one-cycle result strobe.
- RESULT  output  32  result, held stable until the next accepted START.
- RD_OUT  output  5  destination tag captured at accept.

Behaviour:
- Reset (RESET=0, asynchronous) forces: state IDLE, BUSY=0, VALID=0, RESULT=0, RD_OUT=0, counter=0, all internal registers=0.
- Operation select from ALUOP[4:2]:
  - 000 MUL (low 32 bits)
  - 001 MULH (signed x signed, high)
  - 010 MULHSU (signed rs1 x unsigned rs2, high)
  - 011 MULHU (high)
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Accept condition: START=1, ALUOP[0]=1, FLUSH=0, and state is IDLE or DONE. Any other START is ignored with no state change.
- At the accept edge N, the unit latches:
  - operand magnitudes (absolute values for signed operands);
  - result-sign and remainder-sign flags;
  - op code and RD_IN.
  - Counter is cleared and the state goes to CALC.
- States:
  - IDLE: BUSY=0, VALID=0. Goes to CALC on accept.
  - CALC: BUSY=1. One unsigned iteration per edge (edges N+1..N+32). After the 32nd iteration the state goes to FIX.
  - FIX: BUSY=1. At edge N+33, applies sign correction (two's complement negate if the flag is set), selects the low or high product or quotient/remainder, writes RESULT, and goes to DONE.
  - DONE: VALID=1 and BUSY=0 for exactly one cycle, between edges N+33 and N+34. Goes to IDLE, or to CALC if an accept occurs in that cycle (back-to-back; VALID still pulses once for the previous op).
- Fixed latency: 33 cycles from the accept edge to VALID, for every op including the special cases below.
- Division special cases (RISC-V spec), selected at FIX from flags latched at accept:
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return DATA1.
  - Signed overflow (DATA1=0x80000000, DATA2=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Width rules:
  - Multiply uses a 64-bit product register.
  - MULHSU negates the full 64-bit product when rs1 is negative.
  - Remainder takes the sign of the dividend.
- FLUSH=1 at an edge in CALC or FIX: state goes to IDLE. BUSY drops the next cycle, VALID never pulses, RESULT and RD_OUT keep their old values. FLUSH in DONE suppresses any same-cycle accept but does not cancel the VALID already asserted.
- RESET low mid-operation: immediate return to the reset values. No VALID is produced for the aborted op.
- Operands and ALUOP may change after accept without affecting the result.

Test Plan:
- MUL ALUOP=00001, DATA1=7, DATA2=0xFFFFFFFD, RD_IN=5 -> BUSY for 33 cycles; VALID one cycle at edge N+33 with RESULT=0xFFFFFFEB, RD_OUT=5.
- High multiplies:
  - MULH 00101, 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 01101, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 01001, 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV 10001, -7/2 -> 0xFFFFFFFD; REM 11001, -7%2 -> 0xFFFFFFFF; DIVU 10101, 100/7 -> 14; REMU 11101, 100%7 -> 2.
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5%0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - All take exactly 33 cycles.
- FLUSH on the 10th CALC cycle -> BUSY=0 the next cycle, no VALID, RESULT unchanged. A START on the following cycle is accepted and completes normally.
- Control corner cases:
  - START while BUSY is ignored.
  - START with ALUOP=00000 leaves the unit IDLE.
  - START in the DONE cycle gives VALID for the first op, then a second VALID 33 cycles later.
  - RESET pulsed low mid-CALC -> outputs zero immediately and no VALID.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle,
// sign fix-up in a final cycle, fixed 33-cycle latency from accept to VALID.
//
// state | meaning
// IDLE  | waiting for an M-extension START
// CALC  | 32 unsigned iterations on operand magnitudes
// FIX   | sign correction, special cases, RESULT/RD_OUT update
// DONE  | VALID strobe; may accept the next op in this cycle
module mul_div_unit #(
    parameter int WIDTH      = 32,
    parameter int ITERATIONS = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic             FLUSH,
    input  logic [4:0]       ALUOP,
    input  logic [WIDTH-1:0] DATA1,
    input  logic [WIDTH-1:0] DATA2,
    input  logic [4:0]       RD_IN,
    output logic             BUSY,
    output logic             VALID,
    output logic [WIDTH-1:0] RESULT,
    output logic [4:0]       RD_OUT
);
    localparam int W  = WIDTH;
    localparam int CW = $clog2(ITERATIONS);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    op_q;
    logic [4:0]    rd_q, rd_out_q;
    logic [W-1:0]  opa_q, result_q;
    logic [2*W-1:0] prod_q;
    logic          neg_q, dz_q, ovf_q, busy_q, valid_q;

    logic          accept;
    logic [2:0]    op_in;
    logic          s1, s2;
    logic [W-1:0]  abs1, abs2, opa_in, lo_in;
    logic          neg_in, dz_in, ovf_in;
    logic          unused_aluop;

    assign unused_aluop = ALUOP[1];
    assign accept = START & ALUOP[0] & ~FLUSH;
    assign op_in  = ALUOP[4:2];
    assign s1     = DATA1[W-1];
    assign s2     = DATA2[W-1];
    assign abs1   = s1 ? -DATA1 : DATA1;
    assign abs2   = s2 ? -DATA2 : DATA2;
    assign dz_in  = (DATA2 == '0);
    assign ovf_in = (DATA1 == MIN_NEG) && (&DATA2);

    // Multiplies load multiplicand into opa and multiplier into the low half;
    // divides load divisor into opa and dividend into the low half.
    always_comb begin
        opa_in = DATA1;
        lo_in  = DATA2;
        neg_in = 1'b0;
        unique case (op_in)
            3'b000: begin opa_in = DATA1; lo_in = DATA2; neg_in = 1'b0;    end
            3'b001: begin opa_in = abs1;  lo_in = abs2;  neg_in = s1 ^ s2; end
            3'b010: begin opa_in = abs1;  lo_in = DATA2; neg_in = s1;      end
            3'b011: begin opa_in = DATA1; lo_in = DATA2; neg_in = 1'b0;    end
            3'b100: begin opa_in = abs2;  lo_in = abs1;  neg_in = s1 ^ s2; end
            3'b101: begin opa_in = DATA2; lo_in = DATA1; neg_in = 1'b0;    end
            3'b110: begin opa_in = abs2;  lo_in = abs1;  neg_in = s1;      end
            default: begin opa_in = DATA2; lo_in = DATA1; neg_in = 1'b0;   end
        endcase
    end

    logic [W:0]     sum, shifted;
    logic [W-1:0]   diff, new_rem;
    logic           ge;
    logic [2*W-1:0] step_mul, step_div, prod_fix;
    logic [W-1:0]   quo, rem, fix_res;

    always_comb begin
        sum      = {1'b0, prod_q[2*W-1:W]} + (prod_q[0] ? {1'b0, opa_q} : '0);
        step_mul = {sum, prod_q[W-1:1]};
        shifted  = prod_q[2*W-1:W-1];
        ge       = (shifted >= {1'b0, opa_q});
        diff     = shifted[W-1:0] - opa_q;
        new_rem  = ge ? diff : shifted[W-1:0];
        step_div = {new_rem, prod_q[W-2:0], ge};
    end

    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        quo      = prod_q[W-1:0];
        rem      = prod_q[2*W-1:W];
        fix_res  = '0;
        unique case (op_q)
            3'b000:                 fix_res = prod_fix[W-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*W-1:W];
            3'b100: fix_res = dz_q ? '1 : ovf_q ? MIN_NEG : (neg_q ? -quo : quo);
            3'b101: fix_res = dz_q ? '1 : quo;
            3'b110: fix_res = ovf_q ? '0 : (neg_q ? -rem : rem);
            default: fix_res = rem;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            rd_out_q <= '0;
            opa_q    <= '0;
            result_q <= '0;
            prod_q   <= '0;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (accept) begin
                        op_q    <= op_in;
                        rd_q    <= RD_IN;
                        opa_q   <= opa_in;
                        prod_q  <= {{W{1'b0}}, lo_in};
                        neg_q   <= neg_in;
                        dz_q    <= dz_in;
                        ovf_q   <= ovf_in;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (FLUSH) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        prod_q <= op_q[2] ? step_div : step_mul;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(ITERATIONS - 1)) state_q <= FIX;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    if (FLUSH) begin
                        state_q <= IDLE;
                    end else begin
                        result_q <= fix_res;
                        rd_out_q <= rd_q;
                        valid_q  <= 1'b1;
                        state_q  <= DONE;
                    end
                end
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign VALID  = valid_q;
    assign RESULT = result_q;
    assign RD_OUT = rd_out_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: every op class, RV32M division corner cases,
// fixed latency, FLUSH, back-to-back, ignored STARTs and asynchronous reset.
module tb_mul_div_unit;
    logic        CLK = 1'b0;
    logic        RESET, START, FLUSH;
    logic [4:0]  ALUOP, RD_IN, RD_OUT;
    logic [31:0] DATA1, DATA2, RESULT;
    logic        BUSY, VALID;

    int n_cmp = 0;
    int n_err = 0;

    mul_div_unit #(.WIDTH(32), .ITERATIONS(32)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .FLUSH(FLUSH),
        .ALUOP(ALUOP), .DATA1(DATA1), .DATA2(DATA2), .RD_IN(RD_IN),
        .BUSY(BUSY), .VALID(VALID), .RESULT(RESULT), .RD_OUT(RD_OUT)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_start(input logic [4:0] op, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [4:0] rd);
        ALUOP = op; DATA1 = d1; DATA2 = d2; RD_IN = rd; START = 1'b1;
    endtask

    // Accept edge, then scramble the inputs so the result depends only on latched state.
    task automatic accept_edge();
        step();
        START = 1'b0;
        DATA1 = $urandom;
        DATA2 = $urandom;
        ALUOP = 5'b00000;
        RD_IN = 5'd31;
    endtask

    task automatic wait_done(input logic [31:0] exp, input logic [4:0] rd,
                             input string tag, input bit poke);
        int lat = 0;
        bit busy_bad = 1'b0;
        if (BUSY !== 1'b1) busy_bad = 1'b1;
        while (VALID !== 1'b1 && lat < 40) begin
            if (poke && lat == 5) begin
                START = 1'b1; ALUOP = 5'b11101; DATA1 = 32'd9; DATA2 = 32'd4; RD_IN = 5'd9;
            end
            if (poke && lat == 6) START = 1'b0;
            step();
            lat++;
            if (lat < 33 && BUSY !== 1'b1) busy_bad = 1'b1;
        end
        chk({tag, " latency"}, 32'(lat), 32'd33);
        chk({tag, " busy during op"}, {31'd0, busy_bad}, 32'd0);
        chk({tag, " result"}, RESULT, exp);
        chk({tag, " rd_out"}, {27'd0, RD_OUT}, {27'd0, rd});
        chk({tag, " busy in done"}, {31'd0, BUSY}, 32'd0);
    endtask

    task automatic run_op(input logic [4:0] op, input logic [31:0] d1, input logic [31:0] d2,
                          input logic [4:0] rd, input logic [31:0] exp, input string tag);
        drive_start(op, d1, d2, rd);
        accept_edge();
        wait_done(exp, rd, tag, 1'b0);
        step();
        chk({tag, " valid width"}, {31'd0, VALID}, 32'd0);
    endtask

    initial begin
        bit seen;
        RESET = 1'b0; START = 1'b0; FLUSH = 1'b0;
        ALUOP = '0; DATA1 = '0; DATA2 = '0; RD_IN = '0;
        #12;
        chk("reset busy",   {31'd0, BUSY},  32'd0);
        chk("reset valid",  {31'd0, VALID}, 32'd0);
        chk("reset result", RESULT, 32'd0);
        chk("reset rd_out", {27'd0, RD_OUT}, 32'd0);
        RESET = 1'b1;
        step();

        run_op(5'b00001, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, "mul");
        run_op(5'b00101, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, "mulh");
        run_op(5'b01101, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE, "mulhu");
        run_op(5'b01001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8,  32'hFFFFFFFF, "mulhsu");
        run_op(5'b10001, 32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, "div");
        run_op(5'b11001, 32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, "rem");
        run_op(5'b10101, 32'd100,      32'd7,        5'd12, 32'd14,       "divu");
        run_op(5'b11101, 32'd100,      32'd7,        5'd13, 32'd2,        "remu");
        run_op(5'b10101, 32'd5,        32'd0,        5'd14, 32'hFFFFFFFF, "divu by zero");
        run_op(5'b11001, 32'd5,        32'd0,        5'd15, 32'd5,        "rem by zero");
        run_op(5'b10001, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFF, "div by zero");
        run_op(5'b11001, 32'hFFFFFFFB, 32'd0,        5'd17, 32'hFFFFFFFB, "rem neg by zero");
        run_op(5'b10001, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, "div overflow");
        run_op(5'b11001, 32'h80000000, 32'hFFFFFFFF, 5'd19, 32'd0,        "rem overflow");

        // Non-M ALUOP: START must be ignored
        drive_start(5'b00000, 32'd3, 32'd4, 5'd20);
        step();
        START = 1'b0;
        chk("non-m start busy", {31'd0, BUSY}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (VALID === 1'b1) seen = 1'b1;
        end
        chk("non-m start no valid", {31'd0, seen}, 32'd0);
        chk("non-m start result kept", RESULT, 32'd0);

        // START while busy is ignored
        drive_start(5'b00001, 32'd6, 32'd7, 5'd21);
        accept_edge();
        wait_done(32'd42, 5'd21, "start while busy", 1'b1);
        step();
        chk("start while busy valid width", {31'd0, VALID}, 32'd0);

        // FLUSH on the 10th CALC cycle, then a new START the following cycle
        drive_start(5'b10101, 32'd100, 32'd7, 5'd22);
        accept_edge();
        for (int i = 0; i < 9; i++) step();
        FLUSH = 1'b1;
        step();
        FLUSH = 1'b0;
        chk("flush busy drop", {31'd0, BUSY}, 32'd0);
        chk("flush result kept", RESULT, 32'd42);
        chk("flush rd_out kept", {27'd0, RD_OUT}, 32'd21);
        drive_start(5'b11101, 32'd100, 32'd7, 5'd23);
        accept_edge();
        wait_done(32'd2, 5'd23, "after flush", 1'b0);
        step();

        // Back-to-back: accept in the DONE cycle
        drive_start(5'b00001, 32'd3, 32'd5, 5'd24);
        accept_edge();
        wait_done(32'd15, 5'd24, "b2b first", 1'b0);
        drive_start(5'b10001, 32'd20, 32'hFFFFFFFC, 5'd25);
        accept_edge();
        chk("b2b valid single pulse", {31'd0, VALID}, 32'd0);
        wait_done(32'hFFFFFFFB, 5'd25, "b2b second", 1'b0);
        step();
        chk("b2b second valid width", {31'd0, VALID}, 32'd0);

        // Asynchronous reset mid-CALC
        drive_start(5'b00001, 32'd9, 32'd9, 5'd26);
        accept_edge();
        for (int i = 0; i < 5; i++) step();
        #1 RESET = 1'b0;
        #1;
        chk("mid reset busy",   {31'd0, BUSY},  32'd0);
        chk("mid reset valid",  {31'd0, VALID}, 32'd0);
        chk("mid reset result", RESULT, 32'd0);
        chk("mid reset rd_out", {27'd0, RD_OUT}, 32'd0);
        #2 RESET = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (VALID === 1'b1 || BUSY === 1'b1) seen = 1'b1;
        end
        chk("mid reset no valid", {31'd0, seen}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
